// File: rtl/result_checker.sv
// Locks onto a checksum word stream, then counts matching and mismatching beats.
// Optional macro RESULT_CHECKER_RESYNC_EN: ERR_LIMIT consecutive misses re-enter SEARCH instead of FAIL.
module result_checker #(
  parameter int unsigned MAX_SKEW  = 7,
  parameter int unsigned ERR_LIMIT = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             locked,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [31:0]      first_err_data,
  output logic [CNT_W-1:0] resync_cnt
);

  localparam int unsigned MissW = $clog2(ERR_LIMIT + 1);
  localparam logic [CNT_W-1:0] CntOne = 1;
  localparam logic [MissW-1:0] MissOne = 1;
  localparam logic [MissW-1:0] MissLast = MissW'(ERR_LIMIT - 1);

  typedef enum logic [1:0] {StIdle, StSearch, StCheck, StFail} state_e;

  state_e           state_q, state_d;
  logic [31:0]      idx_q, idx_d;
  logic [MissW-1:0] miss_q, miss_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [31:0]      first_q, first_d;
  logic             in_ready_q, in_ready_d;
  logic             locked_q, locked_d;
  logic [32:0]      srch;
  logic             beat;

  function automatic logic [31:0] expected(input logic [31:0] k);
    logic [31:0] c;
    logic [31:0] cl;
    logic [7:0]  pop;
    logic [7:0]  a [4];
    c   = k * 32'd100;
    cl  = (c > 32'd500) ? 32'd500 : c;
    pop = '0;
    for (int b = 0; b < 8; b++) begin
      pop = pop + {7'b0, c[b]};
    end
    foreach (a[i]) begin
      a[i] = k[7:0] * 8'(i + 1);
    end
    return cl ^ {24'b0, pop} ^ (c * 32'd3) ^ {a[3], a[2], a[1], a[0]};
  endfunction

  // Returns {hit, k} for the lowest k in 0..MAX_SKEW whose expected word matches.
  function automatic logic [32:0] search(input logic [31:0] d);
    logic [32:0] r;
    r = '0;
    for (int unsigned k = 0; k <= MAX_SKEW; k++) begin
      if (d == expected(32'(k))) begin
        r = {1'b1, 32'(k)};
        break;
      end
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CntOne;
  endfunction

`ifdef RESULT_CHECKER_RESYNC_EN
  logic [CNT_W-1:0] resync_q, resync_d;
`endif

  assign srch = search(in_data);
  assign beat = in_valid && in_ready_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    miss_d  = miss_q;
    pass_d  = pass_q;
    err_d   = err_q;
    first_d = first_q;
`ifdef RESULT_CHECKER_RESYNC_EN
    resync_d = resync_q;
`endif
    unique case (state_q)
      StIdle: state_d = StSearch;
      StSearch: begin
        if (beat && srch[32]) begin
          state_d = StCheck;
          pass_d  = sat_inc(pass_q);
          idx_d   = srch[31:0] + 32'd1;
          miss_d  = '0;
        end
      end
      StCheck: begin
        if (beat) begin
          idx_d = idx_q + 32'd1;
          if (in_data == expected(idx_q)) begin
            pass_d = sat_inc(pass_q);
            miss_d = '0;
          end else begin
            err_d  = sat_inc(err_q);
            miss_d = miss_q + MissOne;
            if (err_q == '0) begin
              first_d = in_data;
            end
            if (miss_q == MissLast) begin
`ifdef RESULT_CHECKER_RESYNC_EN
              state_d  = StSearch;
              miss_d   = '0;
              resync_d = sat_inc(resync_q);
`else
              state_d  = StFail;
`endif
            end
          end
        end
      end
      StFail: state_d = StFail;
    endcase
    in_ready_d = (state_d == StSearch) || (state_d == StCheck);
    locked_d   = (state_d == StCheck);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      miss_q     <= '0;
      pass_q     <= '0;
      err_q      <= '0;
      first_q    <= '0;
      in_ready_q <= 1'b0;
      locked_q   <= 1'b0;
`ifdef RESULT_CHECKER_RESYNC_EN
      resync_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      miss_q     <= miss_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      first_q    <= first_d;
      in_ready_q <= in_ready_d;
      locked_q   <= locked_d;
`ifdef RESULT_CHECKER_RESYNC_EN
      resync_q   <= resync_d;
`endif
    end
  end

  assign in_ready       = in_ready_q;
  assign locked         = locked_q;
  assign pass_cnt       = pass_q;
  assign err_cnt        = err_q;
  assign first_err_data = first_q;
`ifdef RESULT_CHECKER_RESYNC_EN
  assign resync_cnt     = resync_q;
`else
  assign resync_cnt     = '0;
`endif

endmodule
